// File: rtl/segment_pkg.sv
// Shared types for the ID/EX segment: control bundle, packet, ALU ops.
// Packet widths are fixed by DATA_W / REG_ADDR_W below.
package segment_pkg;

  localparam int DATA_W     = 21;
  localparam int REG_ADDR_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
  } id_ex_ctrl_t;

  typedef struct packed {
    id_ex_ctrl_t           ctrl;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     rd3;
    logic [DATA_W-1:0]     num;
    logic [REG_ADDR_W-1:0] rr3;
  } id_ex_pkt_t;

endpackage

// File: rtl/segment_id_ex_pipe_sat_counter.sv
// Saturating event counter: adds 0..2 per cycle, sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc[1:0], cnt[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc};
    cnt_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/segment_id_ex_pipe.sv
// ID/EX stage: valid/ready both sides, 2-entry skid, flush, bubble squash.
// Ports: clk, rst (async low), flush, in_*/out_* handshakes, stall/flush cnt.
module segment_id_ex_pipe
  import segment_pkg::*;
#(
  parameter int DATA_W     = segment_pkg::DATA_W,
  parameter int REG_ADDR_W = segment_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  id_ex_pkt_t       in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output id_ex_pkt_t       out_pkt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Packet layout lives in the package; parameters must agree with it.
  if (DATA_W != $bits(in_pkt.pc) ||
      REG_ADDR_W != $bits(in_pkt.rr3)) begin : g_bad_w
    $error("segment_id_ex_pipe: width mismatch with segment_pkg");
  end

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_SKID  = 2'b11;

  logic       main_v_q, main_v_d;
  logic       skid_v_q, skid_v_d;
  id_ex_pkt_t main_q, main_d;
  id_ex_pkt_t skid_q, skid_d;

  logic       acc;
  logic       pop;
  logic [1:0] state;
  logic [1:0] stall_inc;
  logic [1:0] flush_inc;

  assign state     = {main_v_q, skid_v_q};
  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_v_d = 1'b1;
            main_d   = in_pkt;
          end
        end
        ST_FULL: begin
          if (acc && pop) begin
            main_d = in_pkt;
          end else if (acc) begin
            skid_v_d = 1'b1;
            skid_d   = in_pkt;
          end else if (pop) begin
            main_v_d = 1'b0;
          end
        end
        ST_SKID: begin
          // Skid drains into main; never bypassed.
          if (pop) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  // Bubbles carry no side effects downstream.
  always_comb begin
    out_pkt = main_q;
    if (!main_v_q) out_pkt.ctrl = '0;
  end

  assign stall_inc = {1'b0, main_v_q & !out_ready};
  assign flush_inc = flush ?
    ({1'b0, main_v_q} + {1'b0, skid_v_q}) : 2'd0;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_segment_id_ex_pipe.sv
// Self-checking bench for segment_id_ex_pipe against a queue model.
// A CNT_W=2 twin shares stimulus to exercise counter saturation.
module tb_segment_id_ex_pipe;
  import segment_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  id_ex_pkt_t  in_pkt;
  logic        in_ready, out_valid;
  id_ex_pkt_t  out_pkt;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_in_ready, s_out_valid;
  id_ex_pkt_t  s_out_pkt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_pkt_t q[$];
  int m_stall, m_flush, m_stall_s, m_flush_s;

  always #5 clk = ~clk;

  segment_id_ex_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  segment_id_ex_pipe #(.CNT_W(2)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_pkt    (in_pkt),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_pkt   (s_out_pkt),
    .stall_cnt (s_stall_cnt),
    .flush_cnt (s_flush_cnt)
  );

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic id_ex_pkt_t rand_pkt();
    id_ex_pkt_t p;
    p.ctrl = id_ex_ctrl_t'($urandom_range(255, 1));
    p.pc   = 21'($urandom);
    p.rd1  = 21'($urandom);
    p.rd2  = 21'($urandom);
    p.rd3  = 21'($urandom);
    p.num  = 21'($urandom);
    p.rr3  = 4'($urandom);
    return p;
  endfunction

  // Advance one clock and apply the queue model for that edge.
  task automatic step();
    int n;
    @(posedge clk);
    n = q.size();
    if (rst) begin
      if (n > 0 && !out_ready) begin
        m_stall   = sat(m_stall + 1, 65535);
        m_stall_s = sat(m_stall_s + 1, 3);
      end
      if (flush) begin
        m_flush   = sat(m_flush + n, 65535);
        m_flush_s = sat(m_flush_s + n, 3);
        q.delete();
      end else begin
        if (n > 0 && out_ready) q.delete(0);
        if (in_valid && n < 2) q.push_back(in_pkt);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_pkt = '0;
    q.delete();
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    n_checks++;
    if (out_pkt !== '0) begin
      n_fail++;
      $display("FAIL reset_out_pkt got %h exp 0", out_pkt);
    end
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0",
               stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  id_ex_pkt_t pa, pb;

  task automatic test_stream();
    pa.ctrl = '{mem_to_reg: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                alu_op: 3'b101, alu_src: 1'b1, reg_write: 1'b1};
    pa.pc = 21'd100; pa.rd1 = 21'd200; pa.rd2 = 21'd300;
    pa.rd3 = 21'd400; pa.num = 21'd500; pa.rr3 = 4'd5;
    pb = pa;
    pb.pc = 21'd600;
    in_pkt = pa; in_valid = 1'b1; out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pkt !== pa) begin
      n_fail++;
      $display("FAIL stream_first got %b/%h exp 1/%h",
               out_valid, out_pkt, pa);
    end
    in_pkt = pb;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pkt.pc !== 21'd600) begin
      n_fail++;
      $display("FAIL stream_second got %b/%0d exp 1/600",
               out_valid, out_pkt.pc);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_bubble();
    n_checks++;
    if (out_valid !== 1'b0 || out_pkt.ctrl !== '0) begin
      n_fail++;
      $display("FAIL bubble_ctrl got %b/%h exp 0/0",
               out_valid, out_pkt.ctrl);
    end
    n_checks++;
    if (out_pkt.pc !== 21'd600 || out_pkt.rd1 !== 21'd200 ||
        out_pkt.num !== 21'd500) begin
      n_fail++;
      $display("FAIL bubble_data got %0d/%0d/%0d exp 600/200/500",
               out_pkt.pc, out_pkt.rd1, out_pkt.num);
    end
  endtask

  task automatic test_back_pressure();
    id_ex_pkt_t p1, p2, p3;
    int base;
    p1 = rand_pkt(); p2 = rand_pkt(); p3 = rand_pkt();
    in_pkt = p1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    base = m_stall;
    in_pkt = p2; out_ready = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready got %b exp 0", in_ready);
    end
    in_pkt = p3;
    step();
    step();
    n_checks++;
    if (int'(stall_cnt) !== base + 3) begin
      n_fail++;
      $display("FAIL bp_stall got %0d exp %0d", stall_cnt, base + 3);
    end
    n_checks++;
    if (out_pkt !== p1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold got %h/%b exp %h/0",
               out_pkt, in_ready, p1);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pkt !== p2) begin
      n_fail++;
      $display("FAIL bp_drain2 got %b/%h exp 1/%h",
               out_valid, out_pkt, p2);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pkt !== p3) begin
      n_fail++;
      $display("FAIL bp_drain3 got %b/%h exp 1/%h",
               out_valid, out_pkt, p3);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush_skid();
    int fbase;
    out_ready = 1'b0; in_valid = 1'b1;
    in_pkt = rand_pkt();
    step();
    in_pkt = rand_pkt();
    step();
    fbase = m_flush;
    flush = 1'b1;
    in_pkt = rand_pkt();
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_pkt.ctrl !== '0 ||
        in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty got %b/%h/%b exp 0/0/1",
               out_valid, out_pkt.ctrl, in_ready);
    end
    n_checks++;
    if (int'(flush_cnt) !== fbase + 2) begin
      n_fail++;
      $display("FAIL flush_cnt got %0d exp %0d", flush_cnt, fbase + 2);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop got %b exp 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pkt = rand_pkt();
    step();
    in_pkt = rand_pkt();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_skid got %b/%b exp 1/0", out_valid, in_ready);
    end
    #1;
    rst = 1'b0;
    q.delete();
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_pkt !== '0) begin
      n_fail++;
      $display("FAIL ar_outputs got %b/%b/%h exp 0/1/0",
               out_valid, in_ready, out_pkt);
    end
    n_checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 ||
        s_stall_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL ar_cnt got %0d/%0d/%0d exp 0/0/0",
               stall_cnt, flush_cnt, s_stall_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; out_ready = 1'b1;
    in_pkt = rand_pkt();
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_checks++;
      if (int'(s_stall_cnt) !== ((i > 3) ? 3 : i) ||
          int'(stall_cnt) !== i) begin
        n_fail++;
        $display("FAIL sat_stall_%0d got %0d/%0d exp %0d/%0d", i,
                 s_stall_cnt, stall_cnt, (i > 3) ? 3 : i, i);
      end
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      flush     = ($urandom_range(15, 0) == 0);
      in_pkt    = rand_pkt();
      step();
      n_checks++;
      if (out_valid !== (q.size() > 0) ||
          in_ready !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rnd_hs c%0d got %b/%b exp %b/%b", c,
                 out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      n_checks++;
      if (q.size() > 0) begin
        if (out_pkt !== q[0]) begin
          n_fail++;
          $display("FAIL rnd_pkt c%0d got %h exp %h", c, out_pkt, q[0]);
        end
      end else if (out_pkt.ctrl !== '0) begin
        n_fail++;
        $display("FAIL rnd_bubble c%0d got %h exp 0", c, out_pkt.ctrl);
      end
      n_checks++;
      if (int'(stall_cnt) !== m_stall ||
          int'(flush_cnt) !== m_flush ||
          int'(s_stall_cnt) !== m_stall_s ||
          int'(s_flush_cnt) !== m_flush_s) begin
        n_fail++;
        $display("FAIL rnd_cnt c%0d got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
                 c, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
                 m_stall, m_flush, m_stall_s, m_flush_s);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bubble();
    test_back_pressure();
    test_flush_skid();
    test_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
